// File: rtl/arb_grant_sink.sv
// arb_grant_sink: receiving end of the round-robin arbiter's grant interface.
// Captures the granted lane and its source index into a small FIFO and
// presents it downstream on valid/ready. stall is a pure flop output so
// that the arbiter's combinational grant path never loops back through here.
module arb_grant_sink #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int SW   = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   grant,
  input  logic [N*W-1:0] req_data,
  output logic           stall,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_src,
  output logic           onehot_err,
  output logic           ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = SW + W;

  // Per-lane view of the packed request data bus.
  logic [W-1:0] lane [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign lane[gi] = req_data[gi*W +: W];
  end

  // FIFO state.
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          stall_q;
  logic          onehot_err_q, onehot_err_d;
  logic          ovf_err_q, ovf_err_d;

  // Grant decode.
  logic [SW-1:0] sel_idx;
  logic [W-1:0]  sel_data;
  logic          any_grant;
  logic          multi_hot;
  logic          full;
  logic          push;
  logic          pop;

  // Lowest-index set grant bit wins, so a non-one-hot grant still stores
  // a consistent {source, data} pair.
  always_comb begin
    logic found;
    sel_idx  = '0;
    sel_data = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant[i] && !found) begin
        sel_idx  = SW'(i);
        sel_data = lane[i];
        found    = 1'b1;
      end
    end
  end

  assign any_grant = |grant;
  assign multi_hot = |(grant & (grant - N'(1)));
  assign full      = (count_q == CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO can still take a beat when the head leaves in the same cycle.
  assign push      = any_grant & (~full | pop);

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    onehot_err_d = onehot_err_q | multi_hot;
    ovf_err_d    = ovf_err_q | (any_grant & full & ~pop);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers; stall mirrors the fullness the FIFO will have next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      stall_q      <= 1'b0;
      onehot_err_q <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      stall_q      <= (count_d == CW'(DEPTH));
      onehot_err_q <= onehot_err_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  // Entry storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {sel_idx, sel_data};
    end
  end

  assign out_data   = mem_q[rd_ptr_q][W-1:0];
  assign out_src    = mem_q[rd_ptr_q][W +: SW];
  assign stall      = stall_q;
  assign onehot_err = onehot_err_q;
  assign ovf_err    = ovf_err_q;

endmodule
